// File: rtl/sig_multadd_acc.sv
`default_nettype none
// ============================================================================
// sig_multadd_acc : N-lane multiply-add with a 4-stage pipelined accumulator
// Revision        : 1.0 - initial release
// ============================================================================
module sig_multadd_acc #(
  parameter int WIDTH_A      = 16,
  parameter int WIDTH_B      = 16,
  parameter int NUM_MULT     = 4,
  parameter int RESULT_WIDTH = 40,
  parameter int SATURATE     = 0
) (
  input  logic                          clock,
  input  logic                          aclr_n,
  input  logic                          ena,
  input  logic                          in_valid,
  input  logic [NUM_MULT*WIDTH_A-1:0]   dataa,
  input  logic [NUM_MULT*WIDTH_B-1:0]   datab,
  input  logic                          sgn,
  input  logic                          accum,
  output logic                          out_valid,
  output logic [RESULT_WIDTH-1:0]       result,
  output logic                          overflow
);

  localparam int c_prod_w = WIDTH_A + WIDTH_B + 1;
  localparam int c_lvls   = $clog2(NUM_MULT);
  localparam int c_sum_w  = c_prod_w + c_lvls;
  localparam int c_leaves = 1 << c_lvls;
  localparam int c_nx_w   = RESULT_WIDTH + 1;

  // ---------------- stage 1 : input registers ----------------
  logic                        r_v1, r_sgn1, r_acc1;
  logic [NUM_MULT*WIDTH_A-1:0] r_a1;
  logic [NUM_MULT*WIDTH_B-1:0] r_b1;

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      r_v1   <= 1'b0;
      r_sgn1 <= 1'b0;
      r_acc1 <= 1'b0;
      r_a1   <= '0;
      r_b1   <= '0;
    end else if (ena) begin
      r_v1   <= in_valid;
      r_sgn1 <= sgn;
      r_acc1 <= accum;
      r_a1   <= dataa;
      r_b1   <= datab;
    end
  end

  // ---------------- stage 2 : lane products ----------------
  // Operands are widened to the full product width so a plain signed
  // multiply serves both signed and unsigned lanes without overflow.
  logic signed [c_prod_w-1:0] w_prod [NUM_MULT];
  logic signed [c_prod_w-1:0] r_prod [NUM_MULT];
  logic                       r_v2, r_sgn2, r_acc2;

  for (genvar i = 0; i < NUM_MULT; i++) begin : g_lane
    logic                       w_sa, w_sb;
    logic signed [c_prod_w-1:0] w_ax, w_bx;
    assign w_sa      = r_sgn1 & r_a1[i*WIDTH_A + WIDTH_A - 1];
    assign w_sb      = r_sgn1 & r_b1[i*WIDTH_B + WIDTH_B - 1];
    assign w_ax      = {{(WIDTH_B+1){w_sa}}, r_a1[i*WIDTH_A +: WIDTH_A]};
    assign w_bx      = {{(WIDTH_A+1){w_sb}}, r_b1[i*WIDTH_B +: WIDTH_B]};
    assign w_prod[i] = w_ax * w_bx;
  end

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      r_v2   <= 1'b0;
      r_sgn2 <= 1'b0;
      r_acc2 <= 1'b0;
      for (int i = 0; i < NUM_MULT; i++) r_prod[i] <= '0;
    end else if (ena) begin
      r_v2   <= r_v1;
      r_sgn2 <= r_sgn1;
      r_acc2 <= r_acc1;
      for (int i = 0; i < NUM_MULT; i++) r_prod[i] <= w_prod[i];
    end
  end

  // ---------------- stage 3 : balanced adder tree ----------------
  for (genvar l = 0; l <= c_lvls; l++) begin : g_lvl
    localparam int c_n = c_leaves >> l;
    logic signed [c_sum_w-1:0] w_s [c_n];
    if (l == 0) begin : g_leaf
      for (genvar j = 0; j < c_n; j++) begin : g_in
        if (j >= NUM_MULT) begin : g_pad
          assign w_s[j] = '0;
        end else if (c_sum_w > c_prod_w) begin : g_ext
          assign w_s[j] = {{(c_sum_w-c_prod_w){r_prod[j][c_prod_w-1]}}, r_prod[j]};
        end else begin : g_eq
          assign w_s[j] = r_prod[j];
        end
      end
    end else begin : g_add
      for (genvar j = 0; j < c_n; j++) begin : g_pair
        assign w_s[j] = g_lvl[l-1].w_s[2*j] + g_lvl[l-1].w_s[2*j+1];
      end
    end
  end

  logic signed [c_sum_w-1:0] r_sum;
  logic                      r_v3, r_sgn3, r_acc3;

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      r_v3   <= 1'b0;
      r_sgn3 <= 1'b0;
      r_acc3 <= 1'b0;
      r_sum  <= '0;
    end else if (ena) begin
      r_v3   <= r_v2;
      r_sgn3 <= r_sgn2;
      r_acc3 <= r_acc2;
      r_sum  <= g_lvl[c_lvls].w_s[0];
    end
  end

  // ---------------- stage 4 : accumulate / saturate ----------------
  logic [RESULT_WIDTH-1:0] r_result;
  logic                    r_out_valid, r_ovf;
  logic [c_nx_w-1:0]       w_base, w_sumx, w_next;
  logic                    w_ovf;
  logic [RESULT_WIDTH-1:0] w_res;

  // The lane sum is always a correct two's-complement value (unsigned sums
  // never reach its top bit), so only the accumulator extension follows sgn.
  always_comb begin
    w_base = '0;
    if (r_acc3) w_base = {r_sgn3 & r_result[RESULT_WIDTH-1], r_result};
    w_sumx = {{(c_nx_w-c_sum_w){r_sum[c_sum_w-1]}}, r_sum};
    w_next = w_base + w_sumx;
    w_ovf  = r_sgn3 ? (w_next[RESULT_WIDTH] ^ w_next[RESULT_WIDTH-1])
                    : w_next[RESULT_WIDTH];
    w_res  = w_next[RESULT_WIDTH-1:0];
    if (w_ovf && (SATURATE != 0)) begin
      if (!r_sgn3)                  w_res = '1;
      else if (w_next[RESULT_WIDTH]) w_res = {1'b1, {(RESULT_WIDTH-1){1'b0}}};
      else                          w_res = {1'b0, {(RESULT_WIDTH-1){1'b1}}};
    end
  end

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_ovf       <= 1'b0;
    end else if (ena) begin
      r_out_valid <= r_v3;
      if (r_v3) begin
        r_result <= w_res;
        if (w_ovf)        r_ovf <= 1'b1;
        else if (!r_acc3) r_ovf <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign overflow  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_sig_multadd_acc.sv
`default_nettype none
// ============================================================================
// tb_sig_multadd_acc : directed table-driven bench for sig_multadd_acc
// Revision           : 1.0 - initial release
// ============================================================================
module tb_sig_multadd_acc;

  logic        clock = 1'b0;
  logic        aclr_n, ena, in_valid, sgn, accum;
  logic [63:0] dataa, datab;
  logic        ov_m, ov_s, ov_w, of_m, of_s, of_w;
  logic [39:0] res_m;
  logic [34:0] res_s, res_w;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clock = ~clock;

  sig_multadd_acc dut_m (
    .clock(clock), .aclr_n(aclr_n), .ena(ena), .in_valid(in_valid),
    .dataa(dataa), .datab(datab), .sgn(sgn), .accum(accum),
    .out_valid(ov_m), .result(res_m), .overflow(of_m));

  sig_multadd_acc #(.RESULT_WIDTH(35), .SATURATE(1)) dut_s (
    .clock(clock), .aclr_n(aclr_n), .ena(ena), .in_valid(in_valid),
    .dataa(dataa), .datab(datab), .sgn(sgn), .accum(accum),
    .out_valid(ov_s), .result(res_s), .overflow(of_s));

  sig_multadd_acc #(.RESULT_WIDTH(35), .SATURATE(0)) dut_w (
    .clock(clock), .aclr_n(aclr_n), .ena(ena), .in_valid(in_valid),
    .dataa(dataa), .datab(datab), .sgn(sgn), .accum(accum),
    .out_valid(ov_w), .result(res_w), .overflow(of_w));

  typedef struct {
    logic [63:0] a, b;
    logic        sg, ac;
    longint      em;  logic om;
    longint      es;  logic os;
    longint      ew;  logic ow;
    logic [1:0]  mask;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [63:0] ln(input int x0, input int x1, input int x2, input int x3);
    return {x3[15:0], x2[15:0], x1[15:0], x0[15:0]};
  endfunction

  function automatic logic [63:0] msk(input longint v, input int w);
    logic [63:0] m;
    m = (64'd1 << w) - 64'd1;
    return v & m;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic add(input logic [63:0] a, input logic [63:0] b, input logic sg, input logic ac,
                     input longint em, input logic om, input longint es, input logic os,
                     input longint ew, input logic ow, input logic [1:0] mask);
    vec_t v;
    v.a = a; v.b = b; v.sg = sg; v.ac = ac;
    v.em = em; v.om = om; v.es = es; v.os = os; v.ew = ew; v.ow = ow; v.mask = mask;
    vecs.push_back(v);
  endtask

  // Issue vecs[first..last] back to back; each result is due 3 edges after issue.
  task automatic run_vecs(input int first, input int last);
    int   n;
    vec_t v;
    n = last - first + 1;
    for (int c = 0; c < n + 3; c++) begin
      if (c < n) begin
        v        = vecs[first + c];
        in_valid = 1'b1;
        dataa    = v.a;
        datab    = v.b;
        sgn      = v.sg;
        accum    = v.ac;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (c >= 3) begin
        v = vecs[first + c - 3];
        if (v.mask[0]) begin
          check($sformatf("vec%0d main out_valid", first + c - 3), {63'd0, ov_m}, 64'd1);
          check($sformatf("vec%0d main result", first + c - 3), {24'd0, res_m}, msk(v.em, 40));
          check($sformatf("vec%0d main overflow", first + c - 3), {63'd0, of_m}, {63'd0, v.om});
        end
        if (v.mask[1]) begin
          check($sformatf("vec%0d sat result", first + c - 3), {29'd0, res_s}, msk(v.es, 35));
          check($sformatf("vec%0d sat overflow", first + c - 3), {63'd0, of_s}, {63'd0, v.os});
          check($sformatf("vec%0d wrap result", first + c - 3), {29'd0, res_w}, msk(v.ew, 35));
          check($sformatf("vec%0d wrap overflow", first + c - 3), {63'd0, of_w}, {63'd0, v.ow});
        end
      end
    end
    tick();
    check("out_valid drops after run", {63'd0, ov_m}, 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " result"}, {24'd0, res_m}, 64'd0);
    check({tag, " out_valid"}, {61'd0, ov_m, ov_s, ov_w}, 64'd0);
    check({tag, " overflow"}, {61'd0, of_m, of_s, of_w}, 64'd0);
    check({tag, " sat/wrap result"}, {res_s[28:0], res_w}, 64'd0);
  endtask

  localparam longint P32 = longint'(1) << 32;
  localparam longint P33 = longint'(1) << 33;
  localparam longint P34 = longint'(1) << 34;

  initial begin
    aclr_n = 1'b0; ena = 1'b1; in_valid = 1'b0; sgn = 1'b0; accum = 1'b0;
    dataa = '0; datab = '0;

    // main-function vectors (default DUT)
    add(ln(1,-2,3,-4), ln(5,6,-7,8), 1, 0, -60, 0, 0, 0, 0, 0, 2'b01);
    add(ln(-1,-1,-1,-1), ln(-1,-1,-1,-1), 0, 0, 64'h3_FFF8_0004, 0, 0, 0, 0, 0, 2'b01);
    add(ln(1,2,3,4), ln(1,1,1,1), 0, 0, 10, 0, 0, 0, 0, 0, 2'b01);
    add(ln(1,2,3,4), ln(1,1,1,1), 0, 1, 20, 0, 0, 0, 0, 0, 2'b01);
    add(ln(1,2,3,4), ln(1,1,1,1), 0, 1, 30, 0, 0, 0, 0, 0, 2'b01);
    add(ln(7,0,0,0), ln(1,0,0,0), 0, 0, 7, 0, 0, 0, 0, 0, 2'b01);
    add(ln(-3,0,0,0), ln(4,0,0,0), 1, 1, -5, 0, 0, 0, 0, 0, 2'b01);
    add(ln(5,0,0,0), ln(1,0,0,0), 0, 1, 0, 1, 0, 0, 0, 0, 2'b01);
    add(ln(3,0,0,0), ln(1,0,0,0), 1, 1, 3, 1, 0, 0, 0, 0, 2'b01);
    add(ln(2,0,0,0), ln(1,0,0,0), 1, 0, 2, 0, 0, 0, 0, 0, 2'b01);
    // saturation / wrap run on the 35-bit instances
    add(ln(-32768,-32768,-32768,-32768), ln(-32768,-32768,-32768,-32768), 1, 0,
        0, 0, P32, 0, P32, 0, 2'b10);
    add(ln(-32768,-32768,-32768,-32768), ln(-32768,-32768,-32768,-32768), 1, 1,
        0, 0, P33, 0, P33, 0, 2'b10);
    add(ln(-32768,-32768,-32768,-32768), ln(-32768,-32768,-32768,-32768), 1, 1,
        0, 0, 3*P32, 0, 3*P32, 0, 2'b10);
    add(ln(-32768,-32768,-32768,-32768), ln(-32768,-32768,-32768,-32768), 1, 1,
        0, 0, P34-1, 1, -P34, 1, 2'b10);
    add(ln(-32768,-32768,-32768,-32768), ln(-32768,-32768,-32768,-32768), 1, 1,
        0, 0, P34-1, 1, -3*P32, 1, 2'b10);
    add(ln(-32768,-32768,-32768,-32768), ln(-32768,-32768,-32768,-32768), 1, 0,
        0, 0, P32, 0, P32, 0, 2'b10);

    #12;
    check_all_zero("power-on reset");
    @(negedge clock) aclr_n = 1'b1;
    tick(); tick();

    run_vecs(0, 9);
    run_vecs(10, 15);

    // reset with three ops in flight
    in_valid = 1'b1; sgn = 1'b0; accum = 1'b0;
    dataa = ln(1,2,3,4); datab = ln(1,1,1,1);
    tick(); tick(); tick();
    #2 aclr_n = 1'b0;
    #1 check_all_zero("async reset");
    in_valid = 1'b0;
    @(negedge clock) aclr_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("post-reset idle %0d out_valid", k), {63'd0, ov_m}, 64'd0);
      check($sformatf("post-reset idle %0d result", k), {24'd0, res_m}, 64'd0);
    end

    // stall: two ops in flight, ena low for three edges with junk on inputs
    in_valid = 1'b1; sgn = 1'b0; accum = 1'b0;
    dataa = ln(1,2,3,4); datab = ln(1,1,1,1);
    tick();
    accum = 1'b1;
    tick();
    ena = 1'b0; accum = 1'b0; dataa = ln(99,0,0,0); datab = ln(1,0,0,0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("stall %0d out_valid", k), {63'd0, ov_m}, 64'd0);
      check($sformatf("stall %0d result", k), {24'd0, res_m}, 64'd0);
    end
    ena = 1'b1; in_valid = 1'b0;
    tick();
    check("stall resume out_valid early", {63'd0, ov_m}, 64'd0);
    tick();
    check("stall op A out_valid", {63'd0, ov_m}, 64'd1);
    check("stall op A result", {24'd0, res_m}, 64'd10);
    tick();
    check("stall op B out_valid", {63'd0, ov_m}, 64'd1);
    check("stall op B result", {24'd0, res_m}, 64'd20);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("stall drain %0d out_valid", k), {63'd0, ov_m}, 64'd0);
      check($sformatf("stall drain %0d result", k), {24'd0, res_m}, 64'd20);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
